// File: rtl/ggf_mem_pkg.sv
// Shared memory-subsystem definitions: refresh FSM states, refresh timing defaults
// and the length of each phase of the refresh strobe sequence.
package ggf_mem_pkg;

   localparam int unsigned REFRESH_DIV_DEF = 109;
   localparam int unsigned MAX_PENDING_DEF = 8;
   localparam int unsigned PEND_W          = 4;

   // Cycles spent in each strobe phase of one refresh (CAS lead, RAS active, precharge)
   localparam int unsigned CAS_LEAD_CYCLES = 1;
   localparam int unsigned RAS_CYCLES      = 2;
   localparam int unsigned PRE_CYCLES      = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CAS  = 3'd1,
      ST_RAS1 = 3'd2,
      ST_RAS2 = 3'd3,
      ST_PRE1 = 3'd4,
      ST_PRE2 = 3'd5
   } ref_state_e;

endpackage

// File: rtl/refresh_tick_gen.sv
// Refresh interval counter: emits a one-cycle tick every REFRESH_DIV clocks,
// the first one REFRESH_DIV-1 edges after reset release.
module refresh_tick_gen #(
   parameter int unsigned REFRESH_DIV = 109
) (
   input  logic CLK,
   input  logic RESETn,
   output logic tick
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Tick is registered alongside the counter so it is high exactly while cnt_q==0
   always_comb begin
      cnt_d  = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
      tick_d = (cnt_d == '0);
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt_q  <= RELOAD;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/ram_refresh_sched.sv
// CAS-before-RAS DRAM refresh scheduler: accumulates owed refreshes from the
// interval tick and runs a 5-cycle strobe sequence when the bus allows.
module ram_refresh_sched
   import ggf_mem_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF,
   parameter int unsigned MAX_PENDING = MAX_PENDING_DEF
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              ASn,
   input  logic              access_busy,
   output logic              ref_ras,
   output logic              ref_cas,
   output logic              hold_access,
   output logic [PEND_W-1:0] pending,
   output logic              overrun
);

   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

   logic              tick;
   ref_state_e        state_q, state_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic              ref_ras_q, ref_ras_d;
   logic              ref_cas_q, ref_cas_d;
   logic              hold_q, hold_d;
   logic              start_c, dec_c;

   refresh_tick_gen #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_tick (
      .CLK    (CLK),
      .RESETn (RESETn),
      .tick   (tick)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      start_c   = (pending_q != '0) && !access_busy && (ASn || (pending_q == PEND_MAX));
      dec_c     = (state_q == ST_CAS);

      // Once started, the sequence ignores the bus and always runs to completion
      case (state_q)
         ST_IDLE: if (start_c) state_d = ST_CAS;
         ST_CAS:  state_d = ST_RAS1;
         ST_RAS1: state_d = ST_RAS2;
         ST_RAS2: state_d = ST_PRE1;
         ST_PRE1: state_d = ST_PRE2;
         ST_PRE2: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A tick and a RAS1 entry on the same cycle cancel, so no overrun either
      if (tick && !dec_c) begin
         if (pending_q == PEND_MAX) overrun_d = 1'b1;
         else                       pending_d = pending_q + PEND_W'(1);
      end else if (dec_c && !tick) begin
         pending_d = pending_q - PEND_W'(1);
      end

      // Outputs decoded from next state so the flops present them in that state's cycle
      ref_cas_d = (state_d == ST_CAS) || (state_d == ST_RAS1) || (state_d == ST_RAS2);
      ref_ras_d = (state_d == ST_RAS1) || (state_d == ST_RAS2);
      hold_d    = (state_d != ST_IDLE) || (pending_d == PEND_MAX);
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         overrun_q <= 1'b0;
         ref_ras_q <= 1'b0;
         ref_cas_q <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         ref_ras_q <= ref_ras_d;
         ref_cas_q <= ref_cas_d;
         hold_q    <= hold_d;
      end
   end

   assign ref_ras     = ref_ras_q;
   assign ref_cas     = ref_cas_q;
   assign hold_access = hold_q;
   assign pending     = pending_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_ram_refresh_sched.sv
// Bench for ram_refresh_sched: cycle-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations at fixed clock edges.
module tb_ram_refresh_sched;

   localparam int DIV  = 109;
   localparam int MAXP = 8;

   logic       CLK;
   logic       RESETn;
   logic       ASn;
   logic       access_busy;
   logic       ref_ras;
   logic       ref_cas;
   logic       hold_access;
   logic [3:0] pending;
   logic       overrun;

   int n_checks = 0;
   int n_errors = 0;
   int cur      = 0;

   ram_refresh_sched #(
      .REFRESH_DIV (DIV),
      .MAX_PENDING (MAXP)
   ) dut (
      .CLK         (CLK),
      .RESETn      (RESETn),
      .ASn         (ASn),
      .access_busy (access_busy),
      .ref_ras     (ref_ras),
      .ref_cas     (ref_cas),
      .hold_access (hold_access),
      .pending     (pending),
      .overrun     (overrun)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model: edges since release, owed count, overrun, and position in the 5-step sequence
   int m_edge, m_pend, m_phase;
   bit m_ovr;
   bit m_tick, m_dec, m_start;

   assign m_tick  = (((m_edge + 1) % DIV) == 0);
   assign m_dec   = (m_phase == 1);
   assign m_start = (m_phase == 0) && (m_pend > 0) && !access_busy && (ASn || (m_pend == MAXP));

   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         m_edge  <= 0;
         m_pend  <= 0;
         m_phase <= 0;
         m_ovr   <= 1'b0;
      end else begin
         m_edge <= m_edge + 1;
         if (m_tick && !m_dec) begin
            if (m_pend >= MAXP) m_ovr <= 1'b1;
            else                m_pend <= m_pend + 1;
         end else if (m_dec && !m_tick) begin
            m_pend <= m_pend - 1;
         end
         if (m_phase == 0)      m_phase <= m_start ? 1 : 0;
         else if (m_phase == 5) m_phase <= 0;
         else                   m_phase <= m_phase + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, cur, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge CLK) begin
      if (RESETn) begin
         chk("model_cas",     int'(ref_cas),     int'(m_phase >= 1 && m_phase <= 3));
         chk("model_ras",     int'(ref_ras),     int'(m_phase == 2 || m_phase == 3));
         chk("model_hold",    int'(hold_access), int'(m_phase != 0 || m_pend == MAXP));
         chk("model_pending", int'(pending),     m_pend);
         chk("model_overrun", int'(overrun),     int'(m_ovr));
      end
   end

   task automatic do_reset(input bit asn, input bit busy);
      RESETn      = 1'b0;
      ASn         = asn;
      access_busy = busy;
      #1;
      chk("rst_ras",     int'(ref_ras),     0);
      chk("rst_cas",     int'(ref_cas),     0);
      chk("rst_hold",    int'(hold_access), 0);
      chk("rst_pending", int'(pending),     0);
      chk("rst_overrun", int'(overrun),     0);
      repeat (3) @(negedge CLK);
      RESETn = 1'b1;
      cur    = 0;
   endtask

   // Advance to 1 time unit after the given posedge (edges counted from reset release)
   task automatic to_edge(input int e);
      repeat (e - cur) @(posedge CLK);
      cur = e;
      #1;
   endtask

   initial begin
      RESETn      = 1'b1;
      ASn         = 1'b1;
      access_busy = 1'b0;
      #2;

      // Idle bus: tick at 109, CAS 110-112, RAS 111-112, busy mid-sequence ignored
      do_reset(1'b1, 1'b0);
      to_edge(108); chk("idle_pend108", int'(pending), 0);
      to_edge(109); chk("idle_pend109", int'(pending), 1);
                    chk("idle_cas109",  int'(ref_cas), 0);
      to_edge(110); chk("idle_cas110",  int'(ref_cas), 1);
                    chk("idle_ras110",  int'(ref_ras), 0);
                    chk("idle_hold110", int'(hold_access), 1);
      to_edge(111); chk("idle_ras111",  int'(ref_ras), 1);
                    chk("idle_pend111", int'(pending), 0);
      @(negedge CLK); access_busy = 1'b1;
      to_edge(112); chk("busy_ras112",  int'(ref_ras), 1);
                    chk("busy_cas112",  int'(ref_cas), 1);
      to_edge(113); chk("pre_cas113",   int'(ref_cas), 0);
                    chk("pre_hold113",  int'(hold_access), 1);
      @(negedge CLK); access_busy = 1'b0;
      to_edge(115); chk("end_hold115",  int'(hold_access), 0);
      to_edge(230);

      // Tick coincides with RAS1 entry; second refresh follows PRE2 after one IDLE cycle
      do_reset(1'b0, 1'b0);
      to_edge(216); chk("co_pend216",   int'(pending), 1);
                    chk("co_cas216",    int'(ref_cas), 0);
      @(negedge CLK); ASn = 1'b1;
      to_edge(217); chk("co_cas217",    int'(ref_cas), 1);
      to_edge(218); chk("co_ras218",    int'(ref_ras), 1);
                    chk("co_pend218",   int'(pending), 1);
      to_edge(222); chk("co_cas222",    int'(ref_cas), 0);
                    chk("co_hold222",   int'(hold_access), 0);
      to_edge(223); chk("co_cas223",    int'(ref_cas), 1);
      to_edge(224); chk("co_pend224",   int'(pending), 0);
      to_edge(240);

      // Bus always busy with ASn: forced refresh only when pending reaches 8
      do_reset(1'b0, 1'b0);
      to_edge(871); chk("sat_pend871",  int'(pending), 7);
                    chk("sat_hold871",  int'(hold_access), 0);
      to_edge(872); chk("sat_pend872",  int'(pending), 8);
                    chk("sat_hold872",  int'(hold_access), 1);
                    chk("sat_cas872",   int'(ref_cas), 0);
      to_edge(873); chk("sat_cas873",   int'(ref_cas), 1);
      to_edge(874); chk("sat_pend874",  int'(pending), 7);
                    chk("sat_ras874",   int'(ref_ras), 1);
      to_edge(900);

      // access_busy held: saturation then overrun, which stays set after draining
      do_reset(1'b0, 1'b1);
      to_edge(980); chk("ovr_pend980",  int'(pending), 8);
                    chk("ovr_flag980",  int'(overrun), 0);
      to_edge(981); chk("ovr_flag981",  int'(overrun), 1);
                    chk("ovr_pend981",  int'(pending), 8);
      @(negedge CLK); ASn = 1'b1; access_busy = 1'b0;
      to_edge(1060); chk("ovr_sticky",  int'(overrun), 1);
                     chk("ovr_drained", int'(pending), 0);

      // Reset pulse during RAS1 drops everything at once; next strobe only after a full interval
      do_reset(1'b1, 1'b0);
      to_edge(111); chk("mid_ras111",   int'(ref_ras), 1);
      #1; RESETn = 1'b0;
      #1; chk("mid_rst_ras",  int'(ref_ras), 0);
          chk("mid_rst_cas",  int'(ref_cas), 0);
          chk("mid_rst_hold", int'(hold_access), 0);
          chk("mid_rst_pend", int'(pending), 0);
      @(negedge CLK); RESETn = 1'b1; cur = 0;
      to_edge(109); chk("post_cas109",  int'(ref_cas), 0);
                    chk("post_pend109", int'(pending), 1);
      to_edge(110); chk("post_cas110",  int'(ref_cas), 1);
      to_edge(120);

      @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
